// File: rtl/vector_fifo_if.sv
// vector_fifo_if: bundles the serial input, the pop request and the FIFO
// status outputs of vector_fifo.
//   serial_bit  producer -> fifo  serial data bit
//   bit_valid   producer -> fifo  serial_bit is accepted on this rising edge
//   req         consumer -> fifo  pop request
//   vector      fifo -> consumer  head vector (all-zeros when empty)
//   valid       fifo -> consumer  head holds an unread entry (count != 0)
//   count       fifo -> consumer  stored vectors, 0..DEPTH
//   overflow    fifo -> consumer  sticky: a completed vector was dropped
// Handshake: the head is transferred on a rising edge where valid=1 and
// req=1 (req plays the role of ready); req with valid=0 has no effect, and
// valid never depends combinationally on req.
interface vector_fifo_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  logic                       serial_bit;
  logic                       bit_valid;
  logic                       req;
  logic [WIDTH-1:0]           vector;
  logic                       valid;
  logic [$clog2(DEPTH+1)-1:0] count;
  logic                       overflow;

  modport master (
    output serial_bit, bit_valid, req,
    input  vector, valid, count, overflow
  );

  modport slave (
    input  serial_bit, bit_valid, req,
    output vector, valid, count, overflow
  );
endinterface

// File: rtl/vector_fifo.sv
// vector_fifo: assembles serial bits into WIDTH-bit vectors and queues them
// in a DEPTH-entry FIFO.
//   clk    rising-edge clock
//   reset  synchronous, active-low reset
//   bus    vector_fifo_if.slave (serial_bit, bit_valid, req in;
//          vector, valid, count, overflow out)
// MSB_FIRST=1: first serial bit ends up in vector[WIDTH-1];
// MSB_FIRST=0: first serial bit ends up in vector[0].
module vector_fifo #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic           clk,
  input  logic           reset,
  vector_fifo_if.slave   bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam int BW = $clog2(WIDTH);

  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shreg_next;
  logic [BW-1:0]    bit_cnt;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [CW-1:0]    cnt;
  logic             ovf;

  logic word_done;
  logic full;
  logic pop;
  logic do_write;

  generate
    if (MSB_FIRST) begin : g_msb
      assign shreg_next = {shreg[WIDTH-2:0], bus.serial_bit};
    end else begin : g_lsb
      assign shreg_next = {bus.serial_bit, shreg[WIDTH-1:1]};
    end
  endgenerate

  assign word_done = bus.bit_valid && (bit_cnt == BW'(WIDTH - 1));
  assign full      = (cnt == CW'(DEPTH));
  // pop requires a stored entry, so a push into an empty FIFO never pops.
  assign pop       = bus.req && (cnt != '0);
  // A full FIFO still accepts a new word when the head leaves on the same edge.
  assign do_write  = word_done && (!full || pop);

  always_ff @(posedge clk) begin
    if (!reset) begin
      shreg   <= '0;
      bit_cnt <= '0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      cnt     <= '0;
      ovf     <= 1'b0;
    end else begin
      if (bus.bit_valid) begin
        shreg   <= shreg_next;
        bit_cnt <= word_done ? '0 : bit_cnt + BW'(1);
      end
      if (do_write) wr_ptr <= wr_ptr + PW'(1);
      if (pop)      rd_ptr <= rd_ptr + PW'(1);
      if (word_done && !do_write) ovf <= 1'b1;
      if (do_write && !pop)       cnt <= cnt + CW'(1);
      else if (pop && !do_write)  cnt <= cnt - CW'(1);
    end
  end

  // Storage is never reset; the output mux below hides stale entries.
  always_ff @(posedge clk) begin
    if (reset && do_write) mem[wr_ptr] <= shreg_next;
  end

  assign bus.valid    = (cnt != '0);
  assign bus.vector   = bus.valid ? mem[rd_ptr] : '0;
  assign bus.count    = cnt;
  assign bus.overflow = ovf;
endmodule

// File: tb/tb_vector_fifo.sv
module tb_vector_fifo;
  localparam int W = 8;
  localparam int D = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vector_fifo_if #(.WIDTH(W), .DEPTH(D)) if_m ();
  vector_fifo_if #(.WIDTH(W), .DEPTH(D)) if_l ();

  vector_fifo #(.WIDTH(W), .DEPTH(D), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .reset(rst_n), .bus(if_m.slave));
  vector_fifo #(.WIDTH(W), .DEPTH(D), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .reset(rst_n), .bus(if_l.slave));

  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  logic       bits_q[$];
  logic [W-1:0] exp_q_m[$];
  logic [W-1:0] exp_q_l[$];
  logic       m_ovf = 1'b0;

  task automatic model_step(input logic r, input logic b, input logic bv, input logic rq);
    logic [W-1:0] wm, wl;
    logic do_pop, do_push;
    if (!r) begin
      bits_q.delete(); exp_q_m.delete(); exp_q_l.delete(); m_ovf = 1'b0;
      return;
    end
    do_pop  = rq && (exp_q_m.size() != 0);
    do_push = 1'b0;
    wm = '0; wl = '0;
    if (bv) begin
      bits_q.push_back(b);
      if (bits_q.size() == W) begin
        for (int i = 0; i < W; i++) begin
          wm[W-1-i] = bits_q[i];
          wl[i]     = bits_q[i];
        end
        bits_q.delete();
        do_push = 1'b1;
      end
    end
    if (do_pop) begin
      void'(exp_q_m.pop_front());
      void'(exp_q_l.pop_front());
    end
    if (do_push) begin
      if (exp_q_m.size() < D) begin
        exp_q_m.push_back(wm);
        exp_q_l.push_back(wl);
      end else begin
        m_ovf = 1'b1;
      end
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic expect_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    logic [W-1:0] em, el;
    em = (exp_q_m.size() != 0) ? exp_q_m[0] : '0;
    el = (exp_q_l.size() != 0) ? exp_q_l[0] : '0;
    expect_eq("msb_vector", 32'(if_m.vector), 32'(em));
    expect_eq("lsb_vector", 32'(if_l.vector), 32'(el));
    expect_eq("msb_valid", 32'(if_m.valid), 32'(exp_q_m.size() != 0));
    expect_eq("lsb_valid", 32'(if_l.valid), 32'(exp_q_l.size() != 0));
    expect_eq("msb_count", 32'(if_m.count), 32'(exp_q_m.size()));
    expect_eq("lsb_count", 32'(if_l.count), 32'(exp_q_l.size()));
    expect_eq("msb_overflow", 32'(if_m.overflow), 32'(m_ovf));
    expect_eq("lsb_overflow", 32'(if_l.overflow), 32'(m_ovf));
  endtask

  // ---------------- driver ----------------
  task automatic cycle(input logic r, input logic b, input logic bv, input logic rq);
    rst_n = r;
    if_m.serial_bit = b; if_m.bit_valid = bv; if_m.req = rq;
    if_l.serial_bit = b; if_l.bit_valid = bv; if_l.req = rq;
    @(posedge clk);
    model_step(r, b, bv, rq);
    #1;
    check_model();
  endtask

  task automatic push_word(input logic [W-1:0] w, input logic rq_last);
    for (int i = W - 1; i >= 0; i--) cycle(1'b1, w[i], 1'b1, (i == 0) ? rq_last : 1'b0);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic       r;
    logic       b;
    logic       bv;
    logic       rq;
    logic [W-1:0] vec_m;
    logic [W-1:0] vec_l;
    logic       vld;
    logic [2:0] cnt;
    logic       ovf;
  } vec_t;

  vec_t tbl[12];

  initial begin
    logic [7:0] seq;
    if_m.serial_bit = 1'b0; if_m.bit_valid = 1'b0; if_m.req = 1'b0;
    if_l.serial_bit = 1'b0; if_l.bit_valid = 1'b0; if_l.req = 1'b0;

    // reset, bits 1,1,0,1,0,0,0,0, a gap, a pop, then a pop on empty
    seq = 8'b1101_0000;
    tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 3'd0, 1'b0};
    for (int i = 0; i < 7; i++)
      tbl[1+i] = '{1'b1, seq[7-i], 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 3'd0, 1'b0};
    tbl[8]  = '{1'b1, seq[0], 1'b1, 1'b0, 8'hD0, 8'h0B, 1'b1, 3'd1, 1'b0};
    tbl[9]  = '{1'b1, 1'b1,  1'b0, 1'b0, 8'hD0, 8'h0B, 1'b1, 3'd1, 1'b0};
    tbl[10] = '{1'b1, 1'b0,  1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 3'd0, 1'b0};
    tbl[11] = '{1'b1, 1'b0,  1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 3'd0, 1'b0};

    @(negedge clk);
    for (int i = 0; i < 12; i++) begin
      cycle(tbl[i].r, tbl[i].b, tbl[i].bv, tbl[i].rq);
      expect_eq($sformatf("tbl%0d_vec_m", i), 32'(if_m.vector), 32'(tbl[i].vec_m));
      expect_eq($sformatf("tbl%0d_vec_l", i), 32'(if_l.vector), 32'(tbl[i].vec_l));
      expect_eq($sformatf("tbl%0d_valid", i), 32'(if_m.valid), 32'(tbl[i].vld));
      expect_eq($sformatf("tbl%0d_count", i), 32'(if_m.count), 32'(tbl[i].cnt));
      expect_eq($sformatf("tbl%0d_ovf", i), 32'(if_m.overflow), 32'(tbl[i].ovf));
    end

    // long bit_valid gap inside a word
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    seq = 8'hA5;
    for (int i = 7; i >= 5; i--) cycle(1'b1, seq[i], 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0);
    expect_eq("gap_count_mid", 32'(if_m.count), 32'd0);
    for (int i = 4; i >= 0; i--) cycle(1'b1, seq[i], 1'b1, 1'b0);
    expect_eq("gap_vector", 32'(if_m.vector), 32'hA5);
    expect_eq("gap_count", 32'(if_m.count), 32'd1);

    // overflow: five words with no reads, then drain
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 5; k++) push_word(8'(k), 1'b0);
    expect_eq("ovf_count", 32'(if_m.count), 32'd4);
    expect_eq("ovf_flag", 32'(if_m.overflow), 32'd1);
    for (int k = 1; k <= 5; k++) begin
      expect_eq($sformatf("drain_head%0d", k), 32'(if_m.vector), (k <= 4) ? 32'(k) : 32'd0);
      cycle(1'b1, 1'b0, 1'b0, 1'b1);
    end
    expect_eq("drain_valid", 32'(if_m.valid), 32'd0);
    expect_eq("drain_ovf_sticky", 32'(if_m.overflow), 32'd1);

    // full FIFO, pop on the edge that completes a new word
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) push_word(8'h11 + 8'(k), 1'b0);
    push_word(8'h15, 1'b1);
    expect_eq("fullpop_count", 32'(if_m.count), 32'd4);
    expect_eq("fullpop_ovf", 32'(if_m.overflow), 32'd0);
    expect_eq("fullpop_head", 32'(if_m.vector), 32'h12);
    for (int k = 0; k < 4; k++) begin
      expect_eq($sformatf("fullpop_drain%0d", k), 32'(if_m.vector), 32'h12 + 32'(k));
      cycle(1'b1, 1'b0, 1'b0, 1'b1);
    end

    // push and req together on an empty FIFO: no pop, word becomes head
    push_word(8'h5A, 1'b1);
    expect_eq("emptypush_head", 32'(if_m.vector), 32'h5A);
    expect_eq("emptypush_count", 32'(if_m.count), 32'd1);

    // reset in the middle of a word discards the partial bits
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 1'b1, 1'b1);
    expect_eq("midreset_count", 32'(if_m.count), 32'd0);
    push_word(8'h3C, 1'b0);
    expect_eq("midreset_vector", 32'(if_m.vector), 32'h3C);
    expect_eq("midreset_count1", 32'(if_m.count), 32'd1);
    expect_eq("midreset_ovf", 32'(if_m.overflow), 32'd0);

    // randomized traffic against the model, alternating read pressure
    for (int n = 0; n < 3000; n++) begin
      logic r, b, bv, rq;
      r  = ($urandom_range(0, 299) != 0);
      b  = 1'($urandom_range(0, 1));
      bv = ($urandom_range(0, 3) != 0);
      if (((n / 400) % 2) == 0) rq = ($urandom_range(0, 15) == 0);
      else                      rq = ($urandom_range(0, 1) == 0);
      cycle(r, b, bv, rq);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/vector_fifo.md
VECTOR_FIFO -- requirements
Module: vector_fifo

Interface
REQ-001 SHALL have parameter: WIDTH, 8, bits per assembled vector (>=2).
REQ-002 SHALL have parameter: DEPTH, 4, FIFO depth in vectors (power of 2, >=2).
REQ-003 SHALL have parameter: MSB_FIRST, 1, bit order; 1 = first serial bit lands in vector[WIDTH-1], 0 = first bit lands in vector[0].
REQ-004 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port: reset  input  1  synchronous, active-low reset.
REQ-006 SHALL have port: bit  input  1  serial data bit.
REQ-007 SHALL have port: bit_valid  input  1  bit is accepted on a rising edge where bit_valid=1.
REQ-008 SHALL have port: req  input  1  consumer pop request.
REQ-009 SHALL have port: vector  output  WIDTH  FIFO head vector.
REQ-010 SHALL have port: valid  output  1  vector holds an unread entry.
REQ-011 SHALL have port: count  output  $clog2(DEPTH+1)  number of stored vectors, 0..DEPTH.
REQ-012 SHALL have port: overflow  output  1  sticky flag; a completed vector was dropped.

Function
REQ-013 SHALL assemble bits in a WIDTH-bit shift register plus a bit counter 0..WIDTH-1; each accepted bit advances the counter.
REQ-014 SHALL, for MSB_FIRST=1, shift left with the new bit entering bit 0; for MSB_FIRST=0, shift right with the new bit entering bit WIDTH-1.
REQ-015 SHALL retain a partial word and its counter unchanged on any edge with bit_valid=0, with no limit on gap length.
REQ-016 SHALL, on the edge accepting the WIDTH-th bit, push the completed word (including that bit) into the FIFO and wrap the bit counter to 0 on that same edge.
REQ-017 SHALL drive valid=1 exactly when count!=0; vector SHALL equal the oldest stored word when valid=1 and all-zeros when valid=0.
REQ-018 SHALL have one-cycle latency: a word completed at edge N is visible on vector/valid immediately after edge N when the FIFO was empty.
REQ-019 SHALL pop the head on a rising edge where req=1 and valid=1; req while valid=0 SHALL be ignored with no state change.
REQ-020 SHALL deliver words in push order; read/write pointers SHALL wrap modulo DEPTH.
REQ-021 SHALL, on push with count=DEPTH and no pop on that edge, drop the new word, leave FIFO contents and count unchanged, and set overflow=1.
REQ-022 SHALL, on simultaneous push and pop, perform both: count unchanged, no overflow even when count=DEPTH; the popped word is the old head.
REQ-023 SHALL, on simultaneous push and pop with count=0, not pop (valid=0); the pushed word becomes head, count=1.
REQ-024 SHALL hold overflow=1 until reset; further pops or pushes SHALL not clear it.
REQ-025 SHALL update count by +1 on push-only, -1 on pop-only, 0 otherwise, never exceeding DEPTH or going below 0.

Reset
REQ-026 SHALL, on an edge with reset=0, clear the shift register, bit counter, read/write pointers, count and overflow; reset overrides bit_valid and req on that edge.
REQ-027 SHALL present vector=0, valid=0, count=0, overflow=0 after reset; a partial word in progress at reset SHALL be discarded.
REQ-028 SHALL need no reset of FIFO storage contents; outputs SHALL not depend on uninitialised storage.

Verification (WIDTH=8, DEPTH=4 unless stated)
REQ-029 SHALL cover: MSB_FIRST=1, bits 1,1,0,1,0,0,0,0 on 8 consecutive edges, req=0 -> after 8th edge vector=8'hD0, valid=1, count=1.
REQ-030 SHALL cover: MSB_FIRST=0, same bit sequence -> vector=8'h0B, valid=1, count=1.
REQ-031 SHALL cover: bit_valid dropped for 5 cycles after 3 bits of 1,0,1,0,0,1,0,1, then resumed -> single word 8'hA5 (MSB_FIRST=1), count=1.
REQ-032 SHALL cover: 5 words 8'h01..8'h05 pushed with req=0 -> count=4, overflow=1 after 5th; then req=1 for 5 cycles -> vectors 01,02,03,04 on successive cycles, then valid=0, overflow stays 1.
REQ-033 SHALL cover: FIFO full, req=1 held on the edge completing a new word -> count stays 4, overflow=0, new word read last.
REQ-034 SHALL cover: reset=0 for one edge after 3 bits of a word -> next 8 bits of 8'h3C yield vector=8'h3C, count=1, overflow=0.
